// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared encodings and defaults for the SR command generator
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    QUAL_HI = 2'd1,
    IDLE_HI = 2'd2,
    QUAL_LO = 2'd3
  } db_state_e;

  localparam int DEF_DB_CYCLES  = 4;
  localparam int DEF_CNT_W      = 5;
  localparam int CONFLICT_CNT_W = 8;

endpackage

// File: rtl/sr_debounce_ch.sv
// rtl/sr_debounce_ch.sv - one request channel: 2-flop synchroniser, debounce FSM, rise strobe
module sr_debounce_ch
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise_evt
);

  if (DB_CYCLES < 1 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_db_cycles
    $error("DB_CYCLES must lie in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DB_VAL  = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  db_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_evt = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = QUAL_HI;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == DB_VAL) begin
          state_d  = IDLE_HI;
          cnt_d    = '0;
          rise_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = QUAL_LO;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == DB_VAL) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accepted level is high while idling high or while a fall is still being qualified.
  assign stable = (state_q == IDLE_HI) || (state_q == QUAL_LO);

endmodule

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - debounced, mutually exclusive s/r pulse generator; SR_CMD_CONFLICT_CNT_EN adds conflict_cnt
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SET_WINS  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic en,
  output logic s,
  output logic r,
  output logic set_lvl,
  output logic clr_lvl,
  output logic conflict
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  localparam logic SW = (SET_WINS != 0);

  logic set_rise, clr_rise;
  logic s_q, s_d;
  logic r_q, r_d;
  logic conflict_q, conflict_d;

  sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_set_ch (
    .clk      (clk),
    .rst      (rst),
    .raw      (set_req),
    .stable   (set_lvl),
    .rise_evt (set_rise)
  );

  sr_debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr_ch (
    .clk      (clk),
    .rst      (rst),
    .raw      (clr_req),
    .stable   (clr_lvl),
    .rise_evt (clr_rise)
  );

  // The losing channel is masked so the flip-flop never sees s and r together.
  always_comb begin
    s_d        = en & set_rise & ~(clr_rise & ~SW);
    r_d        = en & clr_rise & ~(set_rise & SW);
    conflict_d = en & set_rise & clr_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;

`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if (conflict_q && (ccnt_q != '1)) begin
      ccnt_d = ccnt_q + CONFLICT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
    end
  end

  assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - self-checking bench for sr_cmd_gen, r-wins and s-wins instances side by side
module tb_sr_cmd_gen;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic en = 1'b1;

  logic s0, r0, sl0, cl0, cf0;
  logic s1, r1, sl1, cl1, cf1;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] cc0, cc1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(5), .SET_WINS(0)) dut0 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .en(en),
    .s(s0), .r(r0), .set_lvl(sl0), .clr_lvl(cl0), .conflict(cf0)
`ifdef SR_CMD_CONFLICT_CNT_EN
    , .conflict_cnt(cc0)
`endif
  );

  sr_cmd_gen #(.DB_CYCLES(DB), .CNT_W(5), .SET_WINS(1)) dut1 (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .en(en),
    .s(s1), .r(r1), .set_lvl(sl1), .clr_lvl(cl1), .conflict(cf1)
`ifdef SR_CMD_CONFLICT_CNT_EN
    , .conflict_cnt(cc1)
`endif
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a level is accepted once the synchronised input has disagreed with it
  // for DB+1 consecutive samples; a pulse follows only an accepted rise.
  logic       m_sync1 [2];
  logic       m_sync2 [2];
  logic       m_stable[2];
  int         m_run   [2];
  logic       m_raw   [2];
  logic       m_rise  [2];
  logic       e_s0 = 1'b0, e_r0 = 1'b0, e_s1 = 1'b0, e_r1 = 1'b0, e_cf = 1'b0;
  logic [7:0] e_cc = 8'd0;

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_sync1[c] = 1'b0; m_sync2[c] = 1'b0; m_stable[c] = 1'b0; m_run[c] = 0;
    end
    forever begin
      @(posedge clk);
      m_raw[0] = set_req;
      m_raw[1] = clr_req;
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          m_sync1[c] = 1'b0; m_sync2[c] = 1'b0; m_stable[c] = 1'b0; m_run[c] = 0;
        end
        e_s0 = 1'b0; e_r0 = 1'b0; e_s1 = 1'b0; e_r1 = 1'b0; e_cf = 1'b0; e_cc = 8'd0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          m_rise[c] = 1'b0;
          if (m_sync2[c] == m_stable[c]) begin
            m_run[c] = 0;
          end else begin
            m_run[c]++;
            if (m_run[c] == DB + 1) begin
              m_stable[c] = m_sync2[c];
              m_run[c]    = 0;
              m_rise[c]   = m_stable[c];
            end
          end
          m_sync2[c] = m_sync1[c];
          m_sync1[c] = m_raw[c];
        end
        if (e_cf && e_cc != 8'd255) e_cc = e_cc + 8'd1;
        e_s0 = en & m_rise[0] & ~m_rise[1];
        e_r0 = en & m_rise[1];
        e_s1 = en & m_rise[0];
        e_r1 = en & m_rise[1] & ~m_rise[0];
        e_cf = en & m_rise[0] & m_rise[1];
      end
      #1;
      check("s_rwins",   s0,  e_s0);
      check("r_rwins",   r0,  e_r0);
      check("cf_rwins",  cf0, e_cf);
      check("slvl_rwins", sl0, m_stable[0]);
      check("clvl_rwins", cl0, m_stable[1]);
      check("s_swins",   s1,  e_s1);
      check("r_swins",   r1,  e_r1);
      check("cf_swins",  cf1, e_cf);
      check("slvl_swins", sl1, m_stable[0]);
      check("clvl_swins", cl1, m_stable[1]);
      check("excl_rwins", s0 & r0, 1'b0);
      check("excl_swins", s1 & r1, 1'b0);
`ifdef SR_CMD_CONFLICT_CNT_EN
      check("ccnt_rwins", cc0, e_cc);
      check("ccnt_swins", cc1, e_cc);
`endif
    end
  end

  initial begin
    int np;
    repeat (3) tick();
    check("rst_s", s0, 1'b0);
    check("rst_r", r0, 1'b0);
    check("rst_lvl", sl0 | cl0, 1'b0);
    @(negedge clk); rst = 1'b0;
    repeat (3) tick();

    // 1: held set request gives one s pulse on the 7th edge
    @(negedge clk); set_req = 1'b1; np = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t1_s", s0, (k == 7) ? 1'b1 : 1'b0);
      check("t1_lvl", sl0, (k >= 7) ? 1'b1 : 1'b0);
      check("t1_r", r0, 1'b0);
      if (s0) np++;
    end
    check("t1_once", 8'(np), 8'd1);
    @(negedge clk); set_req = 1'b0;
    repeat (10) tick();
    check("t1_lvl_low", sl0, 1'b0);

    // 2: 3-cycle glitch is rejected
    @(negedge clk); set_req = 1'b1; np = 0;
    repeat (3) begin tick(); if (s0) np++; end
    @(negedge clk); set_req = 1'b0;
    repeat (12) begin
      tick();
      if (s0) np++;
      check("t2_lvl", sl0, 1'b0);
    end
    check("t2_none", 8'(np), 8'd0);

    // 3: simultaneous rises
    @(negedge clk); set_req = 1'b1; clr_req = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("t3_r_rwins", r0, (k == 7) ? 1'b1 : 1'b0);
      check("t3_s_rwins", s0, 1'b0);
      check("t3_cf_rwins", cf0, (k == 7) ? 1'b1 : 1'b0);
      check("t3_s_swins", s1, (k == 7) ? 1'b1 : 1'b0);
      check("t3_r_swins", r1, 1'b0);
      check("t3_cf_swins", cf1, (k == 7) ? 1'b1 : 1'b0);
    end
    @(negedge clk); set_req = 1'b0; clr_req = 1'b0;
    repeat (10) tick();

    // 4: reset mid-count discards progress
    @(negedge clk); clr_req = 1'b1;
    repeat (2) tick();
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      tick();
      check("t4_rst_r", r0, 1'b0);
      check("t4_rst_lvl", cl0, 1'b0);
      check("t4_rst_cf", cf0, 1'b0);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("t4_r", r0, (k == 7) ? 1'b1 : 1'b0);
      check("t4_lvl", cl0, (k >= 7) ? 1'b1 : 1'b0);
    end
    @(negedge clk); clr_req = 1'b0;
    repeat (10) tick();

    // 5: disabled pulse is lost, re-armed only by a qualified low
    @(negedge clk); en = 1'b0; set_req = 1'b1;
    repeat (7) tick();
    check("t5_s_off", s0, 1'b0);
    check("t5_lvl", sl0, 1'b1);
    @(negedge clk); en = 1'b1; np = 0;
    repeat (10) begin tick(); if (s0) np++; end
    check("t5_no_defer", 8'(np), 8'd0);
    @(negedge clk); set_req = 1'b0;
    repeat (6) tick();
    @(negedge clk); set_req = 1'b1; np = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t5_s", s0, (k == 7) ? 1'b1 : 1'b0);
      if (s0) np++;
    end
    check("t5_once", 8'(np), 8'd1);
    @(negedge clk); set_req = 1'b0;
    repeat (10) tick();

`ifdef SR_CMD_CONFLICT_CNT_EN
    // 6: saturating conflict counter
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); set_req = 1'b1; clr_req = 1'b1;
      repeat (8) tick();
      @(negedge clk); set_req = 1'b0; clr_req = 1'b0;
      repeat (8) tick();
    end
    check("t6_sat", cc0, 8'd255);
    @(negedge clk); rst = 1'b1;
    tick();
    check("t6_rst", cc0, 8'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
